// File: rtl/fury_pkg.sv
// rtl/fury_pkg.sv - shared game constants for Fury on Wheels
package fury_pkg;

    localparam logic [1:0] EST_IDLE  = 2'd0;
    localparam logic [1:0] EST_RUN   = 2'd1;
    localparam logic [1:0] EST_PAUSA = 2'd2;
    localparam logic [1:0] EST_FIN   = 2'd3;

    localparam int NUM_CARRILES = 3;

endpackage

// File: rtl/contador_bcd.sv
// rtl/contador_bcd.sv - 4-digit BCD incrementer with enable, clear and 9999 saturation
module contador_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] valor
);

    logic [15:0] valor_q;
    logic [15:0] valor_d;
    logic        acarreo;

    always_comb begin
        valor_d = valor_q;
        acarreo = 1'b1;
        if (clr) begin
            valor_d = 16'h0000;
        end else if (en && valor_q != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (acarreo) begin
                    if (valor_q[4*i +: 4] == 4'd9) begin
                        valor_d[4*i +: 4] = 4'd0;
                    end else begin
                        valor_d[4*i +: 4] = valor_q[4*i +: 4] + 4'd1;
                        acarreo = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) valor_q <= 16'h0000;
        else     valor_q <= valor_d;
    end

    assign valor = valor_q;

endmodule

// File: rtl/motor_pista.sv
// rtl/motor_pista.sv - scrolling three-lane road, player lane, score and collision flag
module motor_pista
    import fury_pkg::*;
#(
    parameter int          FILAS    = 8,
    parameter int          DIV_TICK = 2_500_000,
    parameter logic [15:0] SEMILLA  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         estados,
    input  logic               izq,
    input  logic               der,
    output logic [1:0]         carril,
    output logic [3*FILAS-1:0] pista,
    output logic [15:0]        puntos,
    output logic               gameover
);

    localparam int CW = (DIV_TICK > 2) ? $clog2(DIV_TICK) : 1;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [3*FILAS-1:0] pista_q, pista_d;
    logic [1:0]         carril_q, carril_d;
    logic               gameover_q, gameover_d;
    logic               izq_prev_q, der_prev_q;
    logic [1:0]         est_prev_q;
    logic               impar_q, impar_d;

    logic       limpiar, activo, tick;
    logic       izq_ev, der_ev;
    logic [2:0] fila_nueva, ultima;

    always_comb begin
        limpiar = (estados == EST_IDLE) || (est_prev_q == EST_FIN && estados == EST_RUN);
        activo  = (estados == EST_RUN) && !limpiar;
        tick    = activo && (cnt_q == CW'(DIV_TICK - 1));
        izq_ev  = izq_prev_q & ~izq;
        der_ev  = der_prev_q & ~der;
        ultima  = pista_q[3*FILAS-1 -: 3];
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        // Obstacles only on alternate ticks, and never a fully blocked row
        fila_nueva = impar_q ? lfsr_q[2:0] : 3'b000;
        if (fila_nueva == 3'b111) fila_nueva = 3'b101;

        cnt_d      = cnt_q;
        pista_d    = pista_q;
        carril_d   = carril_q;
        gameover_d = gameover_q;
        impar_d    = impar_q;

        if (limpiar) begin
            cnt_d      = '0;
            pista_d    = '0;
            carril_d   = 2'd1;
            gameover_d = 1'b0;
            impar_d    = 1'b1;
        end else if (activo) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                pista_d = {pista_q[3*FILAS-4:0], fila_nueva};
                impar_d = ~impar_q;
            end
            if (izq_ev && !der_ev && carril_q != 2'd0)
                carril_d = carril_q - 2'd1;
            else if (der_ev && !izq_ev && carril_q != 2'(NUM_CARRILES - 1))
                carril_d = carril_q + 2'd1;
            if (ultima[carril_q]) gameover_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            lfsr_q     <= SEMILLA;
            pista_q    <= '0;
            carril_q   <= 2'd1;
            gameover_q <= 1'b0;
            izq_prev_q <= 1'b1;
            der_prev_q <= 1'b1;
            est_prev_q <= EST_IDLE;
            impar_q    <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            pista_q    <= pista_d;
            carril_q   <= carril_d;
            gameover_q <= gameover_d;
            izq_prev_q <= izq;
            der_prev_q <= der;
            est_prev_q <= estados;
            impar_q    <= impar_d;
        end
    end

    contador_bcd u_puntos (
        .clk   (clk),
        .rst   (rst),
        .clr   (limpiar),
        .en    (tick),
        .valor (puntos)
    );

    assign carril   = carril_q;
    assign pista    = pista_q;
    assign gameover = gameover_q;

endmodule

// File: tb/tb_motor_pista.sv
// tb/tb_motor_pista.sv - randomized self-checking bench for motor_pista
module tb_motor_pista;

    localparam int          FILAS    = 8;
    localparam int          DIV_TICK = 4;
    localparam logic [15:0] SEMILLA  = 16'hACE1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         estados = 2'd0;
    logic               izq = 1'b1;
    logic               der = 1'b1;
    logic [1:0]         carril;
    logic [3*FILAS-1:0] pista;
    logic [15:0]        puntos;
    logic               gameover;

    int n_cmp = 0;
    int n_bad = 0;

    motor_pista #(.FILAS(FILAS), .DIV_TICK(DIV_TICK), .SEMILLA(SEMILLA)) dut (
        .clk      (clk),
        .rst      (rst),
        .estados  (estados),
        .izq      (izq),
        .der      (der),
        .carril   (carril),
        .pista    (pista),
        .puntos   (puntos),
        .gameover (gameover)
    );

    always #5 clk = ~clk;

    // Game model: rows as small integers, score as a decimal integer
    int   m_rows [FILAS];
    int   m_score, m_lane, m_cnt, m_lfsr, m_prev;
    bit   m_go, m_odd, m_piz, m_pde;
    int   m_ticks;

    function automatic logic [3*FILAS-1:0] mdl_pista();
        logic [3*FILAS-1:0] v;
        for (int r = 0; r < FILAS; r++) v[3*r +: 3] = 3'(m_rows[r]);
        return v;
    endfunction

    function automatic logic [15:0] mdl_bcd();
        return {4'(m_score / 1000), 4'((m_score / 100) % 10), 4'((m_score / 10) % 10), 4'(m_score % 10)};
    endfunction

    task automatic mdl_update(input int s, input bit i, input bit d, input bit r);
        int  fb, nl, nr;
        bit  clear, run, tick, fi, fd;
        fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        nl = (m_lfsr >> 1) | (fb << 15);
        if (r) begin
            foreach (m_rows[k]) m_rows[k] = 0;
            m_score = 0; m_lane = 1; m_cnt = 0; m_lfsr = SEMILLA;
            m_prev = 0; m_go = 0; m_odd = 1; m_piz = 1; m_pde = 1;
            m_ticks = 0;
            return;
        end
        clear = (s == 0) || (m_prev == 3 && s == 1);
        run   = (s == 1) && !clear;
        tick  = run && (m_cnt == DIV_TICK - 1);
        fi    = m_piz && !i;
        fd    = m_pde && !d;
        if (clear) begin
            foreach (m_rows[k]) m_rows[k] = 0;
            m_score = 0; m_lane = 1; m_cnt = 0; m_go = 0; m_odd = 1;
        end else if (run) begin
            if ((m_rows[FILAS-1] >> m_lane) & 1) m_go = 1;
            if (tick) begin
                for (int k = FILAS - 1; k > 0; k--) m_rows[k] = m_rows[k-1];
                nr = m_odd ? (m_lfsr & 7) : 0;
                if (nr == 7) nr = 5;
                m_rows[0] = nr;
                m_odd = !m_odd;
                if (m_score < 9999) m_score++;
                m_cnt = 0;
                m_ticks++;
            end else begin
                m_cnt++;
            end
            if (fi && !fd && m_lane > 0) m_lane--;
            else if (fd && !fi && m_lane < 2) m_lane++;
        end
        m_piz = i; m_pde = d; m_prev = s; m_lfsr = nl;
    endtask

    task automatic step(input logic [1:0] s, input logic i, input logic d, input logic r);
        estados = s; izq = i; der = d; rst = r;
        @(posedge clk);
        mdl_update(int'(s), i, d, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(2'd1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({carril, pista, puntos, gameover} !== {2'd1, {3*FILAS{1'b0}}, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: carril=%0d pista=%h puntos=%h go=%b, want 1/0/0000/0", carril, pista, puntos, gameover);
        end
    endtask

    task automatic test_first_tick();
        step(2'd0, 1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= DIV_TICK; c++) begin
            step(2'd1, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (puntos !== ((c == DIV_TICK) ? 16'h0001 : 16'h0000) || carril !== 2'd1) begin
                n_bad++;
                $display("FAIL first_tick c%0d: puntos=%h carril=%0d, want %h/1", c, puntos, carril,
                         (c == DIV_TICK) ? 16'h0001 : 16'h0000);
            end
            n_cmp++;
            if ({pista, gameover} !== {mdl_pista(), m_go}) begin
                n_bad++;
                $display("FAIL first_tick_grid c%0d: pista=%h go=%b, want %h/%b", c, pista, gameover, mdl_pista(), m_go);
            end
        end
    endtask

    task automatic test_lane_moves();
        logic [1:0] want [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
        step(2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k < 3)      step(2'd1, 1'b0, 1'b1, 1'b0);
            else if (k < 6) step(2'd1, 1'b1, 1'b0, 1'b0);
            else            step(2'd1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (carril !== want[k] || carril !== 2'(m_lane)) begin
                n_bad++;
                $display("FAIL lane_move %0d: carril=%0d, want %0d", k, carril, want[k]);
            end
            step(2'd1, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_collision();
        int  budget = 3000;
        step(2'd0, 1'b1, 1'b1, 1'b0);
        while (!m_go && budget > 0) begin
            step(2'd1, 1'($urandom), 1'($urandom), 1'b0);
            budget--;
            n_cmp++;
            if ({carril, pista, puntos, gameover} !== {2'(m_lane), mdl_pista(), mdl_bcd(), m_go}) begin
                n_bad++;
                $display("FAIL collide_run: carril=%0d pista=%h puntos=%h go=%b, want %0d/%h/%h/%b",
                         carril, pista, puntos, gameover, m_lane, mdl_pista(), mdl_bcd(), m_go);
            end
        end
        n_cmp++;
        if (budget == 0) begin
            n_bad++;
            $display("FAIL collide_timeout: gameover=%b, want 1 within 3000 cycles", gameover);
        end
        for (int c = 0; c < 10; c++) begin
            step(2'd3, 1'($urandom), 1'($urandom), 1'b0);
            n_cmp++;
            if (gameover !== 1'b1) begin
                n_bad++;
                $display("FAIL collide_sticky c%0d: gameover=%b, want 1", c, gameover);
            end
        end
        step(2'd0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (gameover !== 1'b0 || carril !== 2'd1) begin
            n_bad++;
            $display("FAIL collide_idle_clear: gameover=%b carril=%0d, want 0/1", gameover, carril);
        end
    endtask

    task automatic test_pause();
        logic [3*FILAS-1:0] sp;
        logic [15:0]        su;
        logic [1:0]         sl;
        step(2'd0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) step(2'd1, 1'b1, 1'b1, 1'b0);
        sp = mdl_pista(); su = mdl_bcd(); sl = 2'(m_lane);
        for (int c = 0; c < 20; c++) begin
            step(2'd2, 1'(c % 2), 1'((c / 2) % 2), 1'b0);
            n_cmp++;
            if ({pista, puntos, carril} !== {sp, su, sl}) begin
                n_bad++;
                $display("FAIL pause_hold c%0d: pista=%h puntos=%h carril=%0d, want %h/%h/%0d",
                         c, pista, puntos, carril, sp, su, sl);
            end
        end
        for (int c = 0; c < 2 * DIV_TICK; c++) begin
            step(2'd1, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if ({carril, pista, puntos} !== {2'(m_lane), mdl_pista(), mdl_bcd()}) begin
                n_bad++;
                $display("FAIL pause_resume c%0d: pista=%h puntos=%h carril=%0d, want %h/%h/%0d",
                         c, pista, puntos, carril, mdl_pista(), mdl_bcd(), m_lane);
            end
        end
    endtask

    task automatic test_restart();
        for (int c = 0; c < 6 * DIV_TICK; c++) step(2'd1, 1'($urandom), 1'($urandom), 1'b0);
        step(2'd3, 1'b1, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({pista, puntos, gameover, carril} !== {{3*FILAS{1'b0}}, 16'h0000, 1'b0, 2'd1}) begin
            n_bad++;
            $display("FAIL restart: pista=%h puntos=%h go=%b carril=%0d, want 0/0000/0/1", pista, puntos, gameover, carril);
        end
    endtask

    task automatic test_saturation();
        bit seen100 = 0;
        int after   = 0;
        int budget  = 45000;
        step(2'd0, 1'b1, 1'b1, 1'b0);
        while (after < 2 && budget > 0) begin
            int pre_ticks = m_ticks;
            step(2'd1, 1'($urandom), 1'($urandom), 1'b0);
            budget--;
            n_cmp++;
            if ({carril, pista, puntos, gameover} !== {2'(m_lane), mdl_pista(), mdl_bcd(), m_go}) begin
                n_bad++;
                $display("FAIL sat_run: carril=%0d pista=%h puntos=%h go=%b, want %0d/%h/%h/%b",
                         carril, pista, puntos, gameover, m_lane, mdl_pista(), mdl_bcd(), m_go);
            end
            for (int r = 0; r < FILAS; r++) begin
                if (pista[3*r +: 3] === 3'b111) begin
                    n_cmp++; n_bad++;
                    $display("FAIL row_full: row %0d = 111, want not 111", r);
                end
            end
            if (m_score == 100 && !seen100) begin
                seen100 = 1;
                n_cmp++;
                if (puntos !== 16'h0100) begin
                    n_bad++;
                    $display("FAIL bcd_carry: puntos=%h, want 0100", puntos);
                end
            end
            if (m_ticks != pre_ticks && m_score == 9999 && (after > 0 || m_ticks >= 9999)) begin
                after++;
                n_cmp++;
                if (puntos !== 16'h9999) begin
                    n_bad++;
                    $display("FAIL bcd_sat %0d: puntos=%h, want 9999", after, puntos);
                end
            end
        end
        n_cmp++;
        if (budget == 0) begin
            n_bad++;
            $display("FAIL sat_timeout: puntos=%h, want 9999 reached twice", puntos);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_tick();
        test_lane_moves();
        test_collision();
        test_pause();
        test_restart();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
